// File: rtl/chdr_16sc_to_8sc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | chdr_16sc_to_8sc                                                           |
// | Zero-latency CHDR packet converter: sc16 payload to sc8, header rewrite.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module chdr_16sc_to_8sc #(
    parameter logic [7:0] BASE = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        set_stb,
    input  logic [7:0]  set_addr,
    input  logic [31:0] set_data,
    input  logic [63:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [63:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam logic [1:0] S_HDR    = 2'd0;
    localparam logic [1:0] S_TIME   = 2'd1;
    localparam logic [1:0] S_PAY_LO = 2'd2;
    localparam logic [1:0] S_PAY_HI = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [31:0] hold_q, hold_d;
    logic [16:0] ctrl_q, ctrl_d;

    logic        rdy, vld, last, beat;
    logic [63:0] data;
    logic [15:0] h_len, out_len;
    logic [31:0] conv;
    logic        unused_set_data;

    assign unused_set_data = ^set_data[31:17];

    // Round-to-nearest via +128 before the arithmetic shift; only +128 can overflow.
    function automatic logic [7:0] sat8(input logic [15:0] x);
        logic signed [16:0] t;
        t = $signed({x[15], x}) + 17'sd128;
        t = t >>> 8;
        if (t > 17'sd127)
            return 8'h7F;
        else if (t < -17'sd128)
            return 8'h80;
        else
            return t[7:0];
    endfunction

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        ctrl_d  = ctrl_q;
        rdy     = 1'b0;
        vld     = 1'b0;
        last    = 1'b0;
        data    = 64'h0;
        h_len   = i_tdata[61] ? 16'd16 : 16'd8;
        out_len = h_len + ((i_tdata[47:32] - h_len) >> 1);
        conv    = {sat8(i_tdata[63:48]), sat8(i_tdata[47:32]),
                   sat8(i_tdata[31:16]), sat8(i_tdata[15:0])};

        if (set_stb && (set_addr == BASE))
            ctrl_d = set_data[16:0];

        case (state_q)
            S_HDR: begin
                vld  = i_tvalid;
                rdy  = o_tready;
                last = i_tlast;
                data = {i_tdata[63:48], out_len,
                        ctrl_q[16] ? {i_tdata[15:0], ctrl_q[15:0]} : i_tdata[31:0]};
            end
            S_TIME: begin
                vld  = i_tvalid;
                rdy  = o_tready;
                last = i_tlast;
                data = i_tdata;
            end
            S_PAY_LO: begin
                if (i_tlast) begin
                    vld  = i_tvalid;
                    rdy  = o_tready;
                    last = 1'b1;
                    data = {conv, 32'h0};
                end else begin
                    rdy = 1'b1;
                end
            end
            default: begin
                vld  = i_tvalid;
                rdy  = o_tready;
                last = i_tlast;
                data = {hold_q, conv};
            end
        endcase

        beat = i_tvalid & rdy;
        if (beat) begin
            case (state_q)
                S_HDR:    state_d = i_tlast ? S_HDR : (i_tdata[61] ? S_TIME : S_PAY_LO);
                S_TIME:   state_d = i_tlast ? S_HDR : S_PAY_LO;
                S_PAY_LO: begin
                    state_d = i_tlast ? S_HDR : S_PAY_HI;
                    if (!i_tlast)
                        hold_d = conv;
                end
                default:  state_d = i_tlast ? S_HDR : S_PAY_LO;
            endcase
        end
    end

    // Outputs are forced quiet for as long as reset is held low.
    assign i_tready = reset & rdy;
    assign o_tvalid = reset & vld;
    assign o_tlast  = reset & last;
    assign o_tdata  = reset ? data : 64'h0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_HDR;
            hold_q  <= 32'h0;
            ctrl_q  <= 17'h0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            ctrl_q  <= ctrl_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_chdr_16sc_to_8sc.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_chdr_16sc_to_8sc                                                        |
// | Directed and random-backpressure bench for the sc16 to sc8 converter.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_chdr_16sc_to_8sc;

    localparam logic [7:0] BASE = 8'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = 8'h0;
    logic [31:0] set_data = 32'h0;
    logic [63:0] i_tdata = 64'h0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [63:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit rnd_rdy = 1'b0;

    logic [64:0] outq[$];
    logic [64:0] expq[$];
    logic [63:0] in_beats[$];

    chdr_16sc_to_8sc #(.BASE(BASE)) dut (
        .clk(clk), .reset(reset),
        .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
        .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 clk = ~clk;

    // Inputs and o_tready only change just after posedge, so negedge shows the handshake.
    always @(negedge clk)
        if (reset && o_tvalid && o_tready)
            outq.push_back({o_tlast, o_tdata});

    always @(posedge clk) begin
        #1;
        o_tready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    function automatic logic [7:0] cv(input logic [15:0] x);
        int t;
        t = {{16{x[15]}}, x};
        t = (t + 128) >>> 8;
        if (t > 127)  t = 127;
        if (t < -128) t = -128;
        return t[7:0];
    endfunction

    function automatic logic [31:0] cv32(input logic [63:0] w);
        return {cv(w[63:48]), cv(w[47:32]), cv(w[31:16]), cv(w[15:0])};
    endfunction

    function automatic void model(input bit en, input logic [15:0] dest);
        logic [63:0] hdr, oh;
        int h, l, nl, n, p;
        expq.delete();
        hdr = in_beats[0];
        n   = in_beats.size();
        h   = hdr[61] ? 16 : 8;
        l   = hdr[47:32];
        nl  = h + (l - h) / 2;
        oh  = hdr;
        oh[47:32] = nl[15:0];
        if (en) oh[31:0] = {hdr[15:0], dest};
        expq.push_back({n == 1, oh});
        p = 1;
        if (hdr[61] && n > 1) begin
            expq.push_back({n == 2, in_beats[1]});
            p = 2;
        end
        while (p < n) begin
            if (p == n - 1) begin
                expq.push_back({1'b1, cv32(in_beats[p]), 32'h0});
                p = p + 1;
            end else begin
                expq.push_back({p + 1 == n - 1, cv32(in_beats[p]), cv32(in_beats[p + 1])});
                p = p + 2;
            end
        end
    endfunction

    task automatic set_write(input logic [7:0] a, input logic [31:0] d);
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic drive_beat(input logic [63:0] d, input logic l);
        bit acc = 1'b0;
        i_tdata = d; i_tlast = l; i_tvalid = 1'b1;
        for (int k = 0; k < 200 && !acc; k++) begin
            @(negedge clk);
            acc = i_tready;
            @(posedge clk); #1;
        end
        i_tvalid = 1'b0;
        if (!acc) begin
            n_cmp++; n_fail++;
            $display("FAIL beat_timeout: i_tready stayed 0, required 1");
        end
    endtask

    task automatic send_pkt();
        for (int i = 0; i < in_beats.size(); i++)
            drive_beat(in_beats[i], i == in_beats.size() - 1);
    endtask

    task automatic test_reset();
        i_tvalid = 1'b1; i_tlast = 1'b1; i_tdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #22;
        n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL rst_o_tvalid: got %b want 0", o_tvalid); end
        n_cmp++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL rst_i_tready: got %b want 0", i_tready); end
        n_cmp++; if (o_tlast !== 1'b0)  begin n_fail++; $display("FAIL rst_o_tlast: got %b want 0", o_tlast); end
        n_cmp++; if (o_tdata !== 64'h0) begin n_fail++; $display("FAIL rst_o_tdata: got %h want 0", o_tdata); end
        i_tvalid = 1'b0; i_tlast = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_time_pkt();
        set_write(BASE, 32'h0001_FEED);
        in_beats = '{64'h2000_0020_DEAD_BEEF, 64'h0123_4567_89AB_CDEF,
                     64'h7FFF_8000_00FF_0100, 64'h0080_FF7F_1234_5678};
        expq = '{{1'b0, 64'h2000_0018_BEEF_FEED}, {1'b0, 64'h0123_4567_89AB_CDEF},
                 {1'b1, 64'h7F80_0101_01FF_1256}};
        outq.delete();
        send_pkt();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL time_pkt_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
            n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL time_pkt_beat%0d: got %h want %h", k, got, expq[k]); end
        end
    endtask

    task automatic test_no_time();
        set_write(BASE, 32'h0000_0000);
        in_beats = '{64'h0000_0010_1234_5678, 64'h7F80_7F7F_8000_FF80};
        expq = '{{1'b0, 64'h0000_000C_1234_5678}, {1'b1, 64'h7F7F_8000_0000_0000}};
        outq.delete();
        send_pkt();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL no_time_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
            n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL no_time_beat%0d: got %h want %h", k, got, expq[k]); end
        end
    endtask

    task automatic test_zero_payload();
        outq.delete();
        drive_beat(64'h0000_0008_AAAA_BBBB, 1'b1);
        n_cmp++; if (outq.size() != 1) begin n_fail++; $display("FAIL zero_pay_count: got %0d want 1", outq.size()); end
        n_cmp++;
        if (outq.size() < 1 || outq[0] !== {1'b1, 64'h0000_0008_AAAA_BBBB}) begin
            n_fail++; $display("FAIL zero_pay_beat: got %h want %h", (outq.size() > 0) ? outq[0] : 65'h0, {1'b1, 64'h0000_0008_AAAA_BBBB});
        end
    endtask

    task automatic test_saturation();
        in_beats = '{64'h0000_0018_0000_0001, 64'h7F80_7F7F_8000_FF80, 64'hFF7F_0000_0080_007F};
        expq = '{{1'b0, 64'h0000_0010_0000_0001}, {1'b1, 64'h7F7F_8000_FF00_0100}};
        outq.delete();
        send_pkt();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL sat_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
            n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL sat_beat%0d: got %h want %h", k, got, expq[k]); end
        end
    endtask

    task automatic test_settings_midpacket();
        set_write(BASE, 32'h0001_1111);
        outq.delete();
        drive_beat(64'h0000_0018_0000_ABCD, 1'b0);
        drive_beat(64'h0, 1'b0);
        set_write(BASE, 32'h0001_2222);
        set_write(BASE + 8'd1, 32'h0001_3333);
        drive_beat(64'h0, 1'b1);
        drive_beat(64'h0000_0008_0000_5555, 1'b1);
        expq = '{{1'b0, 64'h0000_0010_ABCD_1111}, {1'b1, 64'h0},
                 {1'b1, 64'h0000_0008_5555_2222}};
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL set_mid_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
            n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL set_mid_beat%0d: got %h want %h", k, got, expq[k]); end
        end
    endtask

    task automatic test_random_backpressure();
        set_write(BASE, 32'h0001_CAFE);
        rnd_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            bit ht = 1'($urandom_range(0, 1));
            int npay = $urandom_range(1, 16);
            int h = ht ? 16 : 8;
            int l = h + 8 * npay;
            in_beats.delete();
            in_beats.push_back({2'($urandom), ht, 13'($urandom), l[15:0], $urandom});
            if (ht) in_beats.push_back({$urandom, $urandom});
            for (int b = 0; b < npay; b++) in_beats.push_back({$urandom, $urandom});
            model(1'b1, 16'hCAFE);
            outq.delete();
            send_pkt();
            n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL rand_count pkt%0d: got %0d want %0d", p, outq.size(), expq.size()); end
            for (int k = 0; k < expq.size(); k++) begin
                logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
                n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL rand_pkt%0d_beat%0d: got %h want %h", p, k, got, expq[k]); end
            end
        end
        rnd_rdy = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midpacket();
        set_write(BASE, 32'h0001_7777);
        drive_beat(64'h0000_0030_0000_0001, 1'b0);
        for (int b = 0; b < 3; b++) drive_beat({$urandom, $urandom}, 1'b0);
        reset = 1'b0;
        i_tvalid = 1'b1; i_tlast = 1'b0; i_tdata = 64'h7FFF_7FFF_7FFF_7FFF;
        #2;
        n_cmp++; if (o_tvalid !== 1'b0) begin n_fail++; $display("FAIL midrst_o_tvalid: got %b want 0", o_tvalid); end
        n_cmp++; if (i_tready !== 1'b0) begin n_fail++; $display("FAIL midrst_i_tready: got %b want 0", i_tready); end
        n_cmp++; if (o_tdata !== 64'h0) begin n_fail++; $display("FAIL midrst_o_tdata: got %h want 0", o_tdata); end
        n_cmp++; if (o_tlast !== 1'b0)  begin n_fail++; $display("FAIL midrst_o_tlast: got %b want 0", o_tlast); end
        @(posedge clk); #1;
        i_tvalid = 1'b0;
        reset = 1'b1;
        in_beats = '{64'h0000_0018_1234_5678, 64'h7F80_7F7F_8000_FF80, 64'hFF7F_0000_0080_007F};
        expq = '{{1'b0, 64'h0000_0010_1234_5678}, {1'b1, 64'h7F7F_8000_FF00_0100}};
        outq.delete();
        send_pkt();
        n_cmp++; if (outq.size() != expq.size()) begin n_fail++; $display("FAIL post_rst_count: got %0d want %0d", outq.size(), expq.size()); end
        for (int k = 0; k < expq.size(); k++) begin
            logic [64:0] got = (k < outq.size()) ? outq[k] : 'x;
            n_cmp++; if (got !== expq[k]) begin n_fail++; $display("FAIL post_rst_beat%0d: got %h want %h", k, got, expq[k]); end
        end
    endtask

    initial begin
        test_reset();
        test_time_pkt();
        test_no_time();
        test_zero_payload();
        test_saturation();
        test_settings_midpacket();
        test_random_backpressure();
        test_reset_midpacket();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
